// File: rtl/spi_reg_pkg.sv
// -----------------------------------------------------------------------------
// spi_reg_pkg
// Shared types and constants for the SPI register bridge:
//   - state_t       : bridge FSM states
//   - CMD_*         : command byte field positions
//   - ST_*          : status byte field positions
// -----------------------------------------------------------------------------
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WRITE,
    READ,
    ERR
  } state_t;

  // Command byte: {rd, addr[6:0]}
  localparam int CMD_RD_BIT   = 7;
  localparam int CMD_ADDR_MSB = 6;

  // Status byte: {addr_err, underrun, xact_cnt[5:0]}
  localparam int ST_ADDR_ERR  = 7;
  localparam int ST_UNDERRUN  = 6;
  localparam int ST_CNT_MSB   = 5;

endpackage

// File: rtl/spi_reg_bank.sv
// -----------------------------------------------------------------------------
// spi_reg_bank
// Register array behind the SPI bridge. Register 0 is a read-only ID value;
// writes addressed to it are dropped and produce no strobe.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   wr_en        : write request (one clk)
//   wr_addr      : register address for the write
//   wr_data      : data to write
//   rd_addr      : combinational read address
//   rd_data      : combinational read data
//   reg_q        : flattened register contents, register k at [8k+7:8k]
//   wr_stb       : registered strobe, one clk per accepted write
//   wr_stb_addr  : address of the accepted write, valid with wr_stb
// -----------------------------------------------------------------------------
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int         NREGS    = 16,
  parameter int         DATA_WDT = 8,
  parameter logic [7:0] ID_VALUE = 8'hA2,
  parameter int         AW       = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [DATA_WDT-1:0]       wr_data,
  input  logic [AW-1:0]             rd_addr,
  output logic [DATA_WDT-1:0]       rd_data,
  output logic [NREGS*DATA_WDT-1:0] reg_q,
  output logic                      wr_stb,
  output logic [AW-1:0]             wr_stb_addr
);

  logic [DATA_WDT-1:0] regs [NREGS];

  // NOTE: the array is reset like any other state, because the register bank
  // has architecturally defined reset contents; it is small and built from
  // flops, not a RAM macro, so a reset costs nothing in inference.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
      regs[0]     <= ID_VALUE;
      wr_stb      <= 1'b0;
      wr_stb_addr <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (wr_en && (wr_addr != '0)) begin
        regs[wr_addr] <= wr_data;
        wr_stb        <= 1'b1;
        wr_stb_addr   <= wr_addr;
      end
    end
  end

  assign rd_data = regs[rd_addr];

  for (genvar k = 0; k < NREGS; k++) begin : g_flat
    assign reg_q[k*DATA_WDT +: DATA_WDT] = regs[k];
  end

endmodule

// File: rtl/spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// spi_reg_bridge
// Byte-protocol register bridge on the receive/transmit word interface of an
// 8-bit SPI slave. The first word of a transaction is a command
// {rd, addr[6:0]}; subsequent words are auto-incrementing burst writes or
// reads of the internal register bank. Between commands the slave is handed
// a status byte {addr_err, underrun, xact_cnt[5:0]} (flags read-to-clear).
//
// Build option: define SPI_REG_BRIDGE_ECHO_EN to make write bursts return the
// previous contents of each overwritten register one word later; otherwise
// write bursts transmit 0x00.
//
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   spi_start    : one-clk pulse at transaction start (ssel fall)
//   spi_end      : one-clk pulse, spi_rx_data holds a complete word
//   spi_rx_data  : received word
//   spi_tx_load  : one-clk pulse, slave consumed spi_tx_data
//   spi_tx_data  : registered word for the slave to send next
//   reg_q        : flattened register contents, register k at [8k+7:8k]
//   reg_wr_stb   : one-clk pulse per register write
//   reg_wr_addr  : address of the written register, valid with reg_wr_stb
// -----------------------------------------------------------------------------
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int         NREGS    = 16,
  parameter int         DATA_WDT = 8,
  parameter logic [7:0] ID_VALUE = 8'hA2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      spi_start,
  input  logic                      spi_end,
  input  logic [DATA_WDT-1:0]       spi_rx_data,
  input  logic                      spi_tx_load,
  output logic [DATA_WDT-1:0]       spi_tx_data,
  output logic [NREGS*DATA_WDT-1:0] reg_q,
  output logic                      reg_wr_stb,
  output logic [$clog2(NREGS)-1:0]  reg_wr_addr
);

  localparam int AW = $clog2(NREGS);

  state_t              state;
  logic [AW-1:0]       addr;
  logic                addr_err;
  logic                underrun;
  logic [ST_CNT_MSB:0] xact_cnt;
  logic                fresh;     // spi_tx_data updated since the last load
  logic                clr_done;  // status already consumed this transaction

  // spi_start takes priority; a coincident spi_end is dropped.
  logic          end_ev;
  logic [AW-1:0] cmd_addr;
  logic          cmd_bad;
  logic          cmd_rd;
  logic          flag_clr;
  logic          aerr_set;
  logic          under_set;

  assign end_ev   = spi_end && !spi_start;
  assign cmd_addr = spi_rx_data[AW-1:0];
  assign cmd_bad  = {1'b0, spi_rx_data[CMD_ADDR_MSB:0]} >= 8'(NREGS);
  assign cmd_rd   = spi_rx_data[CMD_RD_BIT];
  assign flag_clr = (state == CMD) && spi_tx_load && !clr_done && !spi_start;
  assign aerr_set = (state == CMD) && end_ev && cmd_bad;
  // A load coinciding with a word end counts as freshly supplied data.
  assign under_set = (state == READ) && spi_tx_load && !fresh && !end_ev &&
                     !spi_start;

  logic [DATA_WDT-1:0] status_next;
  logic                aerr_next;
  logic                under_next;
  logic [ST_CNT_MSB:0] cnt_next;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through it can leave a value held and infer a latch.
  always_comb begin
    aerr_next   = aerr_set  | (addr_err & ~flag_clr);
    under_next  = under_set | (underrun & ~flag_clr);
    cnt_next    = spi_start ? xact_cnt + 1'b1 : xact_cnt;
    status_next = '0;
    status_next[ST_ADDR_ERR]    = aerr_next;
    status_next[ST_UNDERRUN]    = under_next;
    status_next[ST_CNT_MSB:0]   = cnt_next;
  end

  // Register bank: in CMD the read port looks at the incoming command so the
  // first read word is available on the decode edge.
  logic                wr_en;
  logic [AW-1:0]       rd_addr;
  logic [DATA_WDT-1:0] rd_data;

  assign wr_en   = (state == WRITE) && end_ev;
  assign rd_addr = (state == CMD) ? cmd_addr : addr;

  spi_reg_bank #(
    .NREGS    (NREGS),
    .DATA_WDT (DATA_WDT),
    .ID_VALUE (ID_VALUE),
    .AW       (AW)
  ) u_bank (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (addr),
    .wr_data     (spi_rx_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .reg_q       (reg_q),
    .wr_stb      (reg_wr_stb),
    .wr_stb_addr (reg_wr_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      spi_tx_data <= '0;
      addr_err    <= 1'b0;
      underrun    <= 1'b0;
      xact_cnt    <= '0;
      fresh       <= 1'b0;
      clr_done    <= 1'b0;
    end else begin
      addr_err <= aerr_next;
      underrun <= under_next;
      xact_cnt <= cnt_next;

      if (flag_clr) clr_done <= 1'b1;

      if (spi_start || (end_ev && (state != IDLE) && (state != ERR)))
        fresh <= 1'b1;
      else if (spi_tx_load)
        fresh <= 1'b0;

      if (spi_start) begin
        state       <= CMD;
        spi_tx_data <= status_next;
        clr_done    <= 1'b0;
      end else begin
        case (state)
          IDLE: spi_tx_data <= status_next;
          CMD: begin
            if (end_ev) begin
              addr <= cmd_addr;
              if (cmd_bad) begin
                state       <= ERR;
                spi_tx_data <= '0;
              end else if (cmd_rd) begin
                state       <= READ;
                spi_tx_data <= rd_data;
                addr        <= cmd_addr + 1'b1;
              end else begin
                state       <= WRITE;
                spi_tx_data <= '0;
              end
            end else begin
              spi_tx_data <= status_next;
            end
          end
          WRITE: begin
            if (end_ev) begin
              addr <= addr + 1'b1;
`ifdef SPI_REG_BRIDGE_ECHO_EN
              spi_tx_data <= rd_data;  // contents before this write lands
`else
              spi_tx_data <= '0;
`endif
            end
          end
          READ: begin
            if (end_ev) begin
              spi_tx_data <= rd_data;
              addr        <= addr + 1'b1;
            end
          end
          ERR:     spi_tx_data <= '0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_bridge
// Self-checking bench for spi_reg_bridge (NREGS=16). A transaction-level
// model of the register bank and status byte predicts every transmit word and
// every register write; predictions are queued as stimulus is generated and
// popped when the DUT presents a word (spi_tx_load) or a write strobe.
// -----------------------------------------------------------------------------
module tb_spi_reg_bridge;

  localparam int NR = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            spi_start;
  logic            spi_end;
  logic [7:0]      spi_rx_data;
  logic            spi_tx_load;
  logic [7:0]      spi_tx_data;
  logic [NR*8-1:0] reg_q;
  logic            reg_wr_stb;
  logic [3:0]      reg_wr_addr;

  spi_reg_bridge #(.NREGS(NR), .DATA_WDT(8), .ID_VALUE(8'hA2)) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_start   (spi_start),
    .spi_end     (spi_end),
    .spi_rx_data (spi_rx_data),
    .spi_tx_load (spi_tx_load),
    .spi_tx_data (spi_tx_data),
    .reg_q       (reg_q),
    .reg_wr_stb  (reg_wr_stb),
    .reg_wr_addr (reg_wr_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- model and scoreboard ----------------
  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] mregs [NR];
  int         m_cnt;
  bit         m_aerr;
  bit         m_under;
  logic [7:0] exp_tx [$];
  wr_t        exp_wr [$];

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
    mregs[0] = 8'hA2;
    m_cnt   = 0;
    m_aerr  = 1'b0;
    m_under = 1'b0;
  endtask

  function automatic logic [127:0] model_q();
    logic [127:0] q;
    for (int i = 0; i < NR; i++) q[i*8 +: 8] = mregs[i];
    return q;
  endfunction

  // Status word seen at the start of a new transaction; reading clears flags.
  function automatic logic [7:0] next_status();
    logic [7:0] s;
    m_cnt = (m_cnt + 1) % 64;
    s = {m_aerr, m_under, 6'(m_cnt)};
    m_aerr  = 1'b0;
    m_under = 1'b0;
    return s;
  endfunction

  // Write-strobe monitor: each strobe must match the oldest predicted write.
  always @(posedge clk) begin
    #1;
    if (!reset && reg_wr_stb) begin
      if (exp_wr.size() == 0) begin
        check("wr_unexpected", 1, 0);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        check("wr_addr", reg_wr_addr, w.a);
        check("wr_data", reg_q[w.a*8 +: 8], w.d);
      end
    end
  end

  // ---------------- stimulus primitives ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    spi_start = 1'b1;
    tick(1);
    spi_start = 1'b0;
    tick(2);
  endtask

  // Slave takes spi_tx_data during the load cycle.
  task automatic load_word();
    spi_tx_load = 1'b1;
    if (exp_tx.size() == 0) check("tx_unexpected", 1, 0);
    else check("tx_word", spi_tx_data, exp_tx.pop_front());
    tick(1);
    spi_tx_load = 1'b0;
    tick(2);
  endtask

  // Strobe must appear on the very edge that consumed spi_end.
  task automatic end_word(input logic [7:0] rx, input bit exp_stb);
    spi_end     = 1'b1;
    spi_rx_data = rx;
    tick(1);
    spi_end = 1'b0;
    check("wr_stb_latency", reg_wr_stb, exp_stb);
    tick(2);
  endtask

  // Full transaction: command plus n (<=2) data words.
  task automatic run_xact(input logic [7:0] cmd, input int n,
                          input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] d [2];
    logic [7:0] words [3];
    bit         stb [3];
    int         a;
    int         ad;
    bit         is_bad;
    bit         rd;
    d[0] = d0;
    d[1] = d1;
    a      = int'(cmd[3:0]);
    is_bad = (cmd[6:4] != 3'd0);
    rd     = cmd[7];
    words[0] = next_status();
    words[1] = (is_bad || !rd) ? 8'h00 : mregs[a];
    stb[0]   = 1'b0;
    for (int j = 0; j < n; j++) begin
      logic [7:0] nxt;
      ad = (a + j) % NR;
      stb[j+1] = !is_bad && !rd && (ad != 0);
      if (is_bad)  nxt = 8'h00;
      else if (rd) nxt = mregs[(a + j + 1) % NR];
      else begin
`ifdef SPI_REG_BRIDGE_ECHO_EN
        nxt = mregs[ad];
`else
        nxt = 8'h00;
`endif
      end
      if (j + 2 <= n) words[j+2] = nxt;
      if (stb[j+1]) begin
        exp_wr.push_back('{a: 4'(ad), d: d[j]});
        mregs[ad] = d[j];
      end
    end
    if (is_bad) m_aerr = 1'b1;

    do_start();
    for (int k = 0; k <= n; k++) begin
      exp_tx.push_back(words[k]);
      load_word();
      end_word((k == 0) ? cmd : d[k-1], stb[k]);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset       = 1'b1;
    spi_start   = 1'b0;
    spi_end     = 1'b0;
    spi_rx_data = 8'h00;
    spi_tx_load = 1'b0;
    model_reset();
    tick(3);
    check("rst_reg_q", reg_q, model_q());
    check("rst_tx", spi_tx_data, 8'h00);
    check("rst_stb", reg_wr_stb, 1'b0);
    check("rst_wr_addr", reg_wr_addr, 4'h0);
    reset = 1'b0;
    tick(2);
    check("idle_tx", spi_tx_data, 8'h00);

    // Write burst, then read it back.
    run_xact(8'h01, 2, 8'h5A, 8'hC3);
    check("wr_burst_q", reg_q, model_q());
    run_xact(8'h81, 2, 8'h00, 8'h00);

    // Register 0 protected; read wraps 15 -> 0.
    run_xact(8'h00, 1, 8'h11, 8'h00);
    check("reg0_q", reg_q, model_q());
    run_xact(8'h8F, 2, 8'h00, 8'h00);

    // Address error, then sticky flag seen once and cleared.
    run_xact(8'h20, 2, 8'hEE, 8'hDD);
    check("aerr_q", reg_q, model_q());
    run_xact(8'h8E, 1, 8'h00, 8'h00);
    run_xact(8'h8E, 1, 8'h00, 8'h00);

    // Underrun: two loads in READ with no word end between them.
    do_start();
    exp_tx.push_back(next_status());
    load_word();
    end_word(8'h81, 1'b0);
    exp_tx.push_back(mregs[1]);
    load_word();
    exp_tx.push_back(mregs[1]);
    load_word();
    end_word(8'h00, 1'b0);
    m_under = 1'b1;
    run_xact(8'h82, 1, 8'h00, 8'h00);
    run_xact(8'h82, 1, 8'h00, 8'h00);

    // spi_start and spi_end together: start wins, the word is dropped.
    do_start();
    exp_tx.push_back(next_status());
    load_word();
    end_word(8'h06, 1'b0);
    exp_tx.push_back(8'h00);
    load_word();
    spi_start   = 1'b1;
    spi_end     = 1'b1;
    spi_rx_data = 8'h99;
    tick(1);
    spi_start = 1'b0;
    spi_end   = 1'b0;
    check("start_wins_stb", reg_wr_stb, 1'b0);
    tick(2);
    exp_tx.push_back(next_status());
    load_word();
    end_word(8'h86, 1'b0);
    exp_tx.push_back(mregs[6]);
    load_word();
    end_word(8'h00, 1'b0);
    check("start_wins_q", reg_q, model_q());

    // Reset in the middle of a write burst.
    do_start();
    exp_tx.push_back(next_status());
    load_word();
    end_word(8'h03, 1'b0);
    exp_tx.push_back(8'h00);
    load_word();
    exp_wr.push_back('{a: 4'd3, d: 8'h77});
    mregs[3] = 8'h77;
    end_word(8'h77, 1'b1);
    exp_tx.push_back(8'h00);
    load_word();
    exp_wr.push_back('{a: 4'd4, d: 8'h88});
    mregs[4] = 8'h88;
    end_word(8'h88, 1'b1);
    check("pre_rst_q", reg_q, model_q());
    reset = 1'b1;
    tick(2);
    model_reset();
    check("mid_rst_q", reg_q, model_q());
    check("mid_rst_tx", spi_tx_data, 8'h00);
    reset = 1'b0;
    tick(2);
    run_xact(8'h05, 1, 8'h3C, 8'h00);
    run_xact(8'h85, 1, 8'h00, 8'h00);
    check("post_rst_q", reg_q, model_q());

    tick(4);
    check("wr_left", exp_wr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
